// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_pkg : op codes and condition-code bit positions for alu_pipe      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package alu_pkg;

   localparam int ALU_OP_W = 3;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_XOR = 3'd3,
      ALU_OR  = 3'd4,
      ALU_SHL = 3'd5,
      ALU_SHR = 3'd6,
      ALU_SAR = 3'd7
   } alu_op_e;

   // Bit positions inside the {ZF,SF,OF} condition-code vector.
   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_core : combinational 8-op ALU with signed overflow flag           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [ALU_OP_W-1:0] op,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   output logic [WIDTH-1:0]    result,
   output logic                ovf
);

   localparam int SH_W = $clog2(WIDTH);
   localparam int MSB  = WIDTH - 1;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [SH_W-1:0]  sh;

   always_comb begin
      sum    = a + b;
      diff   = a - b;
      sh     = b[SH_W-1:0];
      result = '0;
      ovf    = 1'b0;
      case (alu_op_e'(op))
         ALU_ADD: begin
            result = sum;
            ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
         end
         ALU_SUB: begin
            result = diff;
            ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
         end
         ALU_AND: result = a & b;
         ALU_XOR: result = a ^ b;
         ALU_OR:  result = a | b;
         ALU_SHL: result = a << sh;
         ALU_SHR: result = a >> sh;
         ALU_SAR: result = $signed(a) >>> sh;
         default: result = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_pipe : two-stage valid/ready ALU pipeline owning the Y86 CC reg   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module alu_pipe
   import alu_pkg::*;
#(
   parameter int         WIDTH    = 64,
   parameter int         TAG_W    = 4,
   parameter logic [2:0] CC_RESET = 3'b100
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ALU_OP_W-1:0] in_op,
   input  logic [WIDTH-1:0]    in_a,
   input  logic [WIDTH-1:0]    in_b,
   input  logic                in_set_cc,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_result,
   output logic                out_ovf,
   output logic [TAG_W-1:0]    out_tag,
   output logic [2:0]          cc
);

   logic                s1_valid_q, s1_valid_d;
   logic [ALU_OP_W-1:0] s1_op_q, s1_op_d;
   logic [WIDTH-1:0]    s1_a_q, s1_a_d;
   logic [WIDTH-1:0]    s1_b_q, s1_b_d;
   logic                s1_set_cc_q, s1_set_cc_d;
   logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;

   logic                s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0]    s2_result_q, s2_result_d;
   logic                s2_ovf_q, s2_ovf_d;
   logic                s2_set_cc_q, s2_set_cc_d;
   logic [TAG_W-1:0]    s2_tag_q, s2_tag_d;

   logic [2:0]          cc_q, cc_d;

   logic [WIDTH-1:0]    core_result;
   logic                core_ovf;
   logic                s2_load;
   logic                in_fire;
   logic                retire;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op     (s1_op_q),
      .a      (s1_a_q),
      .b      (s1_b_q),
      .result (core_result),
      .ovf    (core_ovf)
   );

   always_comb begin
      s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
      in_ready = ~flush & (~s1_valid_q | s2_load);
      in_fire  = in_valid & in_ready;
      retire   = s2_valid_q & out_ready & ~flush;

      s1_op_d     = s1_op_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_set_cc_d = s1_set_cc_q;
      s1_tag_d    = s1_tag_q;
      if (in_fire) begin
         s1_op_d     = in_op;
         s1_a_d      = in_a;
         s1_b_d      = in_b;
         s1_set_cc_d = in_set_cc;
         s1_tag_d    = in_tag;
      end

      s2_result_d = s2_result_q;
      s2_ovf_d    = s2_ovf_q;
      s2_set_cc_d = s2_set_cc_q;
      s2_tag_d    = s2_tag_q;
      if (s2_load) begin
         s2_result_d = core_result;
         s2_ovf_d    = core_ovf;
         s2_set_cc_d = s1_set_cc_q;
         s2_tag_d    = s1_tag_q;
      end

      // Flush kills both stages; stale data may stay since valids gate it.
      s1_valid_d = ~flush & (in_fire | (s1_valid_q & ~s2_load));
      s2_valid_d = ~flush & (s2_load | (s2_valid_q & ~out_ready));

      cc_d = cc_q;
      if (retire && s2_set_cc_q) begin
         cc_d[CC_ZF] = (s2_result_q == '0);
         cc_d[CC_SF] = s2_result_q[WIDTH-1];
         cc_d[CC_OF] = s2_ovf_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= '0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_set_cc_q <= 1'b0;
         s1_tag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_ovf_q    <= 1'b0;
         s2_set_cc_q <= 1'b0;
         s2_tag_q    <= '0;
         cc_q        <= CC_RESET;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_set_cc_q <= s1_set_cc_d;
         s1_tag_q    <= s1_tag_d;
         s2_valid_q  <= s2_valid_d;
         s2_result_q <= s2_result_d;
         s2_ovf_q    <= s2_ovf_d;
         s2_set_cc_q <= s2_set_cc_d;
         s2_tag_q    <= s2_tag_d;
         cc_q        <= cc_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_result = s2_result_q;
   assign out_ovf    = s2_ovf_q;
   assign out_tag    = s2_tag_q;
   assign cc         = cc_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_alu_pipe : randomized bench for alu_pipe against a queue model     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        in_set_cc;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic        out_ovf;
   logic [3:0]  out_tag;
   logic [2:0]  cc;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [63:0] res;
      logic        ovf;
      logic [3:0]  tag;
      logic        sc;
      int          age;
   } ent_t;

   ent_t       q[$];
   logic [2:0] m_cc;

   alu_pipe #(.WIDTH(64), .TAG_W(4), .CC_RESET(3'b100)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_set_cc  (in_set_cc),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_ovf    (out_ovf),
      .out_tag    (out_tag),
      .cc         (cc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Reference ALU from the arithmetic definitions, using a 65-bit signed range test for overflow.
   function automatic void ref_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] r, output logic o);
      logic [64:0] wide;
      int unsigned amt;
      amt = int'(b & 64'd63);
      o   = 1'b0;
      r   = '0;
      case (op)
         3'd0: begin wide = {a[63], a} + {b[63], b}; r = wide[63:0]; o = wide[64] ^ wide[63]; end
         3'd1: begin wide = {a[63], a} - {b[63], b}; r = wide[63:0]; o = wide[64] ^ wide[63]; end
         3'd2: r = a & b;
         3'd3: r = a ^ b;
         3'd4: r = a | b;
         3'd5: r = a << amt;
         3'd6: r = a >> amt;
         default: begin
            r = a >> amt;
            if (a[63]) r = r | ~({64{1'b1}} >> amt);
         end
      endcase
   endfunction

   // One clock: drive, check at negedge against the model, then advance the model at posedge.
   task automatic cycle(input logic v, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic sc, input logic [3:0] tag, input logic ordy, input logic fl);
      logic        exp_rdy;
      logic        exp_ov;
      logic [63:0] r;
      logic        o;
      ent_t        e;
      in_valid  = v;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      in_set_cc = sc;
      in_tag    = tag;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      exp_rdy = !fl && (q.size() < 2 || ordy);
      exp_ov  = (q.size() > 0) && (q[0].age >= 1);
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
      if (exp_ov) begin
         chk("out_result", out_result, q[0].res);
         chk("out_ovf", {63'd0, out_ovf}, {63'd0, q[0].ovf});
         chk("out_tag", {60'd0, out_tag}, {60'd0, q[0].tag});
      end
      chk("cc", {61'd0, cc}, {61'd0, m_cc});
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         if (exp_ov && ordy) begin
            if (q[0].sc) m_cc = {q[0].res == 64'd0, q[0].res[63], q[0].ovf};
            void'(q.pop_front());
         end
         foreach (q[i]) q[i].age++;
         if (v && exp_rdy) begin
            ref_alu(op, a, b, r, o);
            e.res = r; e.ovf = o; e.tag = tag; e.sc = sc; e.age = 0;
            q.push_back(e);
         end
      end
      #1;
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 4'd0, ordy, 1'b0);
   endtask

   logic [63:0] ra, rb;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
      in_set_cc = 1'b0; in_tag = '0; out_ready = 1'b0;
      m_cc = 3'b100;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_cc", {61'd0, cc}, 64'd4);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: ADD overflow, two-clock latency
      cycle(1'b1, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd5, 1'b0, 1'b0);
      idle(1'b0);
      chk("t1_valid", {63'd0, out_valid}, 64'd1);
      chk("t1_result", out_result, 64'h8000_0000_0000_0000);
      chk("t1_ovf", {63'd0, out_ovf}, 64'd1);
      idle(1'b1);
      chk("t1_cc", {61'd0, cc}, 64'd3);

      // 2: SUB then AND back to back
      cycle(1'b1, 3'd1, 64'd5, 64'd5, 1'b1, 4'd6, 1'b1, 1'b0);
      cycle(1'b1, 3'd2, 64'hF0, 64'h0F, 1'b0, 4'd7, 1'b1, 1'b0);
      idle(1'b1);
      chk("t2_cc_first", {61'd0, cc}, 64'd4);
      idle(1'b1);
      chk("t2_cc_second", {61'd0, cc}, 64'd4);

      // 3: stall with three offers, then release
      cycle(1'b1, 3'd4, 64'd1, 64'd2, 1'b0, 4'd1, 1'b0, 1'b0);
      cycle(1'b1, 3'd4, 64'd3, 64'd4, 1'b0, 4'd2, 1'b0, 1'b0);
      cycle(1'b1, 3'd4, 64'd5, 64'd6, 1'b0, 4'd3, 1'b0, 1'b0);
      chk("t3_full_ready", {63'd0, in_ready}, 64'd0);
      cycle(1'b1, 3'd4, 64'd5, 64'd6, 1'b0, 4'd3, 1'b1, 1'b0);
      repeat (3) idle(1'b1);

      // 4: arithmetic vs logical right shift
      cycle(1'b1, 3'd7, 64'h8000_0000_0000_0000, 64'h44, 1'b0, 4'd8, 1'b1, 1'b0);
      cycle(1'b1, 3'd6, 64'h8000_0000_0000_0000, 64'h44, 1'b0, 4'd9, 1'b0, 1'b0);
      chk("t4_sar", out_result, 64'hF800_0000_0000_0000);
      chk("t4_sar_ovf", {63'd0, out_ovf}, 64'd0);
      idle(1'b1);
      chk("t4_shr", out_result, 64'h0800_0000_0000_0000);
      idle(1'b1);

      // 5: flush with both stages full
      cycle(1'b1, 3'd0, 64'd1, 64'd1, 1'b1, 4'd10, 1'b0, 1'b0);
      cycle(1'b1, 3'd0, 64'd2, 64'd2, 1'b1, 4'd11, 1'b0, 1'b0);
      cycle(1'b1, 3'd0, 64'd9, 64'd9, 1'b1, 4'd12, 1'b1, 1'b1);
      chk("t5_valid", {63'd0, out_valid}, 64'd0);
      chk("t5_cc", {61'd0, cc}, 64'd4);
      cycle(1'b1, 3'd1, 64'd1, 64'd2, 1'b1, 4'd13, 1'b0, 1'b0);
      idle(1'b0);
      chk("t5_latency", {63'd0, out_valid}, 64'd1);
      idle(1'b1);
      chk("t5_cc_after", {61'd0, cc}, 64'd2);

      // 6: asynchronous reset in the middle of a stall
      cycle(1'b1, 3'd3, 64'd7, 64'd1, 1'b1, 4'd14, 1'b0, 1'b0);
      cycle(1'b1, 3'd3, 64'd8, 64'd1, 1'b1, 4'd15, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("t6_valid", {63'd0, out_valid}, 64'd0);
      chk("t6_cc", {61'd0, cc}, 64'd4);
      chk("t6_result", out_result, 64'd0);
      chk("t6_tag", {60'd0, out_tag}, 64'd0);
      q.delete();
      m_cc = 3'b100;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_ready", {63'd0, in_ready}, 64'd1);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: ra = 64'h7FFF_FFFF_FFFF_FFFF;
            1: ra = 64'h8000_0000_0000_0000;
            2: rb = ra;
            3: rb = 64'($urandom_range(0, 200));
            default: ;
         endcase
         cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), ra, rb,
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
      end
      repeat (4) idle(1'b1);
      chk("drain_empty", {63'd0, out_valid}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
